// File: rtl/data_mem_ctrl.sv
// Byte-addressable data memory controller: SB/SH/SW stores, LB/LH/LW/LBU/LHU loads,
// one outstanding request, loads answered exactly READ_LATENCY cycles after acceptance.
module data_mem_ctrl #(
    parameter int ADDR_WIDTH   = 12,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [1:0]            req_store_type,
    input  logic [2:0]            req_load_type,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err
);
    localparam int         WADDR_W  = ADDR_WIDTH - 2;
    localparam int         WORDS    = 2 ** WADDR_W;
    localparam logic [1:0] CNT_INIT = 2'(READ_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, LOAD_WAIT, RESP} state_t;

    state_t             state_reg;
    logic [1:0]         cnt_reg;
    logic               ready_reg;
    logic               resp_valid_reg;
    logic               resp_err_reg;
    logic               resp_load_reg;
    logic [1:0]         off_reg;
    logic [2:0]         ltype_reg;
    logic [WADDR_W-1:0] waddr_reg;

    logic               accept;
    logic               req_err;
    logic               wr_en;
    logic               rd_en;
    logic [WADDR_W-1:0] req_widx;
    logic [WADDR_W-1:0] rd_idx;
    logic [31:0]        rd_word;
    logic [7:0]         byte_sel;
    logic [15:0]        half_sel;
    logic [31:0]        load_data;

    assign accept   = req_valid && ready_reg;
    assign req_widx = req_addr[ADDR_WIDTH-1:2];
    assign wr_en    = accept && req_write && !req_err;

    always_comb begin
        req_err = 1'b0;
        if (req_write) begin
            case (req_store_type)
                2'b00:   req_err = 1'b0;
                2'b01:   req_err = req_addr[0];
                2'b10:   req_err = |req_addr[1:0];
                default: req_err = 1'b1;
            endcase
        end else begin
            case (req_load_type)
                3'b000, 3'b011: req_err = 1'b0;
                3'b001, 3'b100: req_err = req_addr[0];
                3'b010:         req_err = |req_addr[1:0];
                default:        req_err = 1'b1;
            endcase
        end
    end

    // The word is read on the edge that launches the response, so the data
    // reflects memory as of that edge; with latency 1 that is the acceptance edge.
    assign rd_en  = (accept && !req_write && !req_err && READ_LATENCY == 1) ||
                    (state_reg == LOAD_WAIT && cnt_reg == 2'd1);
    assign rd_idx = (state_reg == IDLE) ? req_widx : waddr_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [WORDS];
            logic [7:0] wbyte;
            logic       we;
            logic [7:0] rd_byte_reg;

            always_comb begin
                case (req_store_type)
                    2'b00:   wbyte = req_wdata[7:0];
                    2'b01:   wbyte = req_wdata[8*(gi%2) +: 8];
                    default: wbyte = req_wdata[8*gi +: 8];
                endcase
                case (req_store_type)
                    2'b00:   we = wr_en && (req_addr[1:0] == 2'(gi));
                    2'b01:   we = wr_en && (req_addr[1] == 1'(gi / 2));
                    default: we = wr_en;
                endcase
            end

            always_ff @(posedge clk) begin
                if (we) begin
                    mem[req_widx] <= wbyte;
                end
                if (rd_en) begin
                    rd_byte_reg <= mem[rd_idx];
                end
            end

            assign rd_word[8*gi +: 8] = rd_byte_reg;
        end
    endgenerate

    always_comb begin
        byte_sel = rd_word[{off_reg, 3'b000} +: 8];
        half_sel = off_reg[1] ? rd_word[31:16] : rd_word[15:0];
        case (ltype_reg)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b011:  load_data = {24'd0, byte_sel};
            3'b100:  load_data = {16'd0, half_sel};
            default: load_data = rd_word;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= 2'd0;
            ready_reg      <= 1'b0;
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            resp_load_reg  <= 1'b0;
            off_reg        <= 2'd0;
            ltype_reg      <= 3'd0;
            waddr_reg      <= '0;
        end else begin
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            resp_load_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    ready_reg <= 1'b1;
                    if (accept) begin
                        ready_reg <= 1'b0;
                        off_reg   <= req_addr[1:0];
                        ltype_reg <= req_load_type;
                        waddr_reg <= req_widx;
                        if (!req_write && !req_err && READ_LATENCY > 1) begin
                            state_reg <= LOAD_WAIT;
                            cnt_reg   <= CNT_INIT;
                        end else begin
                            state_reg      <= RESP;
                            resp_valid_reg <= 1'b1;
                            resp_err_reg   <= req_err;
                            resp_load_reg  <= !req_write && !req_err;
                        end
                    end
                end
                LOAD_WAIT: begin
                    cnt_reg <= cnt_reg - 2'd1;
                    if (cnt_reg == 2'd1) begin
                        state_reg      <= RESP;
                        resp_valid_reg <= 1'b1;
                        resp_load_reg  <= 1'b1;
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b1;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign req_ready  = ready_reg;
    assign resp_valid = resp_valid_reg;
    assign resp_err   = resp_err_reg;
    assign resp_rdata = (resp_valid_reg && resp_load_reg) ? load_data : 32'd0;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: three builds (latency 1, 3, 4) share clock and reset;
// index 0 covers load/store formatting and errors, 1 back-to-back traffic, 2 reset mid-load.
module tb_data_mem_ctrl;
    localparam logic [1:0] SB = 2'b00, SH = 2'b01, SW = 2'b10;
    localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b011, LHU = 3'b100;

    logic        clk;
    logic        rst;
    logic        req_valid      [3];
    logic        req_ready      [3];
    logic        req_write      [3];
    logic [11:0] req_addr       [3];
    logic [31:0] req_wdata      [3];
    logic [1:0]  req_store_type [3];
    logic [2:0]  req_load_type  [3];
    logic        resp_valid     [3];
    logic [31:0] resp_rdata     [3];
    logic        resp_err       [3];

    int n_cmp = 0;
    int n_bad = 0;

    logic        s_wr    [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [11:0] s_addr  [5] = '{12'h020, 12'h020, 12'h021, 12'h020, 12'h021};
    logic [31:0] s_wdata [5] = '{32'h11223344, 32'h0, 32'h000000AA, 32'h0, 32'h0};
    logic [1:0]  s_st    [5] = '{SW, SB, SB, SB, SB};
    logic [2:0]  s_lt    [5] = '{LB, LW, LB, LW, LBU};
    logic [31:0] s_exp   [5] = '{32'h0, 32'h11223344, 32'h0, 32'h1122AA44, 32'h000000AA};
    int          s_lat   [5] = '{1, 3, 1, 3, 3};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            data_mem_ctrl #(
                .ADDR_WIDTH  (12),
                .READ_LATENCY(gi == 0 ? 1 : gi + 2)
            ) u_dut (
                .clk           (clk),
                .rst           (rst),
                .req_valid     (req_valid[gi]),
                .req_ready     (req_ready[gi]),
                .req_write     (req_write[gi]),
                .req_addr      (req_addr[gi]),
                .req_wdata     (req_wdata[gi]),
                .req_store_type(req_store_type[gi]),
                .req_load_type (req_load_type[gi]),
                .resp_valid    (resp_valid[gi]),
                .resp_rdata    (resp_rdata[gi]),
                .resp_err      (resp_err[gi])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", tag, act, exp);
        end
    endtask

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : k + 2;
    endfunction

    task automatic txn(input int k, input string tag, input logic wr, input logic [11:0] addr,
                       input logic [31:0] wdata, input logic [1:0] st, input logic [2:0] lt,
                       input logic [31:0] exp_data, input logic exp_err);
        int n;
        int exp_lat;
        @(negedge clk);
        req_valid[k]      = 1'b1;
        req_write[k]      = wr;
        req_addr[k]       = addr;
        req_wdata[k]      = wdata;
        req_store_type[k] = st;
        req_load_type[k]  = lt;
        n = 0;
        while (!req_ready[k] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, 32'(req_ready[k]), 32'd1);
        @(negedge clk);
        req_valid[k] = 1'b0;
        n = 1;
        while (!resp_valid[k] && n < 20) begin
            @(negedge clk);
            n++;
        end
        exp_lat = (wr || exp_err) ? 1 : lat_of(k);
        check({tag, "_lat"}, 32'(n), 32'(exp_lat));
        check({tag, "_data"}, resp_rdata[k], exp_data);
        check({tag, "_err"}, 32'(resp_err[k]), 32'(exp_err));
        $display("txn %-10s dut=%0d lat=%0d rdata=0x%08h err=%0b", tag, k, n, resp_rdata[k], resp_err[k]);
        @(negedge clk);
        check({tag, "_pulse"}, 32'(resp_valid[k]), 32'd0);
        check({tag, "_idle"}, resp_rdata[k], 32'd0);
    endtask

    initial begin
        int pulses;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req_valid[k]      = 1'b0;
            req_write[k]      = 1'b0;
            req_addr[k]       = 12'h0;
            req_wdata[k]      = 32'h0;
            req_store_type[k] = 2'b00;
            req_load_type[k]  = 3'b000;
        end
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(req_ready[0]), 32'd0);
        check("rst_valid", 32'(resp_valid[0]), 32'd0);
        check("rst_rdata", resp_rdata[0], 32'd0);
        check("rst_err", 32'(resp_err[0]), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 32'(req_ready[0]), 32'd1);

        // word store / load round trip
        txn(0, "sw_dead", 1'b1, 12'h010, 32'hDEADBEEF, SW, LB, 32'h0, 1'b0);
        txn(0, "lw_dead", 1'b0, 12'h010, 32'h0, SB, LW, 32'hDEADBEEF, 1'b0);
        // sign / zero extension of byte and half
        txn(0, "sw_zero", 1'b1, 12'h010, 32'h0, SW, LB, 32'h0, 1'b0);
        txn(0, "sb_80", 1'b1, 12'h013, 32'h00000080, SB, LB, 32'h0, 1'b0);
        txn(0, "lb_13", 1'b0, 12'h013, 32'h0, SB, LB, 32'hFFFFFF80, 1'b0);
        txn(0, "lbu_13", 1'b0, 12'h013, 32'h0, SB, LBU, 32'h00000080, 1'b0);
        txn(0, "lh_12", 1'b0, 12'h012, 32'h0, SB, LH, 32'hFFFF8000, 1'b0);
        txn(0, "lhu_12", 1'b0, 12'h012, 32'h0, SB, LHU, 32'h00008000, 1'b0);
        txn(0, "lw_10", 1'b0, 12'h010, 32'h0, SB, LW, 32'h80000000, 1'b0);
        // halfword lanes
        txn(0, "sw_14", 1'b1, 12'h014, 32'h0, SW, LB, 32'h0, 1'b0);
        txn(0, "sh_14", 1'b1, 12'h014, 32'hFFFF1234, SH, LB, 32'h0, 1'b0);
        txn(0, "sh_16", 1'b1, 12'h016, 32'h0000ABCD, SH, LB, 32'h0, 1'b0);
        txn(0, "lw_14", 1'b0, 12'h014, 32'h0, SB, LW, 32'hABCD1234, 1'b0);
        txn(0, "lb_15", 1'b0, 12'h015, 32'h0, SB, LB, 32'h00000012, 1'b0);
        txn(0, "lh_16", 1'b0, 12'h016, 32'h0, SB, LH, 32'hFFFFABCD, 1'b0);
        // misaligned and illegal requests leave word 0 untouched
        txn(0, "sw_00", 1'b1, 12'h000, 32'h01020304, SW, LB, 32'h0, 1'b0);
        txn(0, "e_sw_02", 1'b1, 12'h002, 32'hFFFFFFFF, SW, LB, 32'h0, 1'b1);
        txn(0, "e_sh_01", 1'b1, 12'h001, 32'hFFFFFFFF, SH, LB, 32'h0, 1'b1);
        txn(0, "e_lw_03", 1'b0, 12'h003, 32'h0, SB, LW, 32'h0, 1'b1);
        txn(0, "e_lhu_01", 1'b0, 12'h001, 32'h0, SB, LHU, 32'h0, 1'b1);
        txn(0, "e_st_11", 1'b1, 12'h000, 32'hFFFFFFFF, 2'b11, LB, 32'h0, 1'b1);
        txn(0, "e_lt_101", 1'b0, 12'h000, 32'h0, SB, 3'b101, 32'h0, 1'b1);
        txn(0, "lw_00", 1'b0, 12'h000, 32'h0, SB, LW, 32'h01020304, 1'b0);

        // latency-3 build with req_valid held high across the whole sequence
        begin : stream
            int  issued;
            int  got;
            int  low_cnt;
            int  extra;
            bit  pend;
            issued  = 0;
            got     = 0;
            low_cnt = 0;
            pend    = 1'b0;
            for (int cyc = 0; cyc < 200 && !(got == 5 && issued == 5 && !pend); cyc++) begin
                @(negedge clk);
                if (pend) begin
                    if (!req_ready[1]) begin
                        low_cnt++;
                    end else begin
                        check($sformatf("s%0d_busy", issued - 1), 32'(low_cnt), 32'(s_lat[issued - 1]));
                        pend = 1'b0;
                    end
                end
                if (resp_valid[1]) begin
                    if (got < 5) begin
                        check($sformatf("s%0d_data", got), resp_rdata[1], s_exp[got]);
                        check($sformatf("s%0d_err", got), 32'(resp_err[1]), 32'd0);
                        check($sformatf("s%0d_lat", got), 32'(low_cnt), 32'(s_lat[got]));
                        $display("txn stream%0d  dut=1 lat=%0d rdata=0x%08h err=%0b", got, low_cnt,
                                 resp_rdata[1], resp_err[1]);
                        got++;
                    end else begin
                        check("s_extra", 32'd1, 32'd0);
                    end
                end
                if (req_ready[1] && !pend) begin
                    if (issued < 5) begin
                        req_valid[1]      = 1'b1;
                        req_write[1]      = s_wr[issued];
                        req_addr[1]       = s_addr[issued];
                        req_wdata[1]      = s_wdata[issued];
                        req_store_type[1] = s_st[issued];
                        req_load_type[1]  = s_lt[issued];
                        pend    = 1'b1;
                        low_cnt = 0;
                        issued++;
                    end else begin
                        req_valid[1] = 1'b0;
                    end
                end
            end
            req_valid[1] = 1'b0;
            check("s_count", 32'(got), 32'd5);
            extra = 0;
            repeat (5) begin
                @(negedge clk);
                extra += int'(resp_valid[1]);
            end
            check("s_tail", 32'(extra), 32'd0);
        end

        // latency-4 build: reset while a load waits
        txn(2, "l4_sw", 1'b1, 12'h040, 32'hCAFEF00D, SW, LB, 32'h0, 1'b0);
        txn(2, "l4_lw", 1'b0, 12'h040, 32'h0, SB, LW, 32'hCAFEF00D, 1'b0);
        @(negedge clk);
        req_valid[2]     = 1'b1;
        req_write[2]     = 1'b0;
        req_addr[2]      = 12'h040;
        req_load_type[2] = LW;
        @(negedge clk);
        req_valid[2] = 1'b0;
        check("l4_wait_ready", 32'(req_ready[2]), 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("l4_rst_valid", 32'(resp_valid[2]), 32'd0);
        check("l4_rst_ready", 32'(req_ready[2]), 32'd0);
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            pulses += int'(resp_valid[2]);
        end
        rst = 1'b1;
        repeat (8) begin
            @(negedge clk);
            pulses += int'(resp_valid[2]);
        end
        check("l4_no_stale", 32'(pulses), 32'd0);
        check("l4_ready_back", 32'(req_ready[2]), 32'd1);
        txn(2, "l4_after", 1'b0, 12'h040, 32'h0, SB, LW, 32'hCAFEF00D, 1'b0);
        txn(0, "l1_after", 1'b0, 12'h010, 32'h0, SB, LW, 32'h80000000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, byte-address width; memory depth is 2**ADDR_WIDTH bytes.
REQ-002 SHALL have parameter READ_LATENCY, default 1, legal range 1-4: load response delay in cycles after acceptance.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  block can accept a request this cycle.
REQ-007 SHALL have port req_write  input  1  1=store, 0=load.
REQ-008 SHALL have port req_addr  input  ADDR_WIDTH  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 SHALL have port req_store_type  input  2  00=SB, 01=SH, 10=SW, 11=illegal.
REQ-011 SHALL have port req_load_type  input  3  000=LB, 001=LH, 010=LW, 011=LBU, 100=LHU, 101-111=illegal.
REQ-012 SHALL have port resp_valid  output  1  single-cycle response pulse.
REQ-013 SHALL have port resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-014 SHALL have port resp_err  output  1  request was misaligned or illegal; qualified by resp_valid.

Function
REQ-015 SHALL accept a request on a rising edge where req_valid and req_ready are both 1; req_* inputs are sampled only then.
REQ-016 SHALL implement FSM IDLE, LOAD_WAIT, RESP; req_ready=1 only in IDLE.
REQ-017 SHALL flag an error when: SH with addr[0]=1; SW with addr[1:0]!=00; LH/LHU with addr[0]=1; LW with addr[1:0]!=00; or illegal type code.
REQ-018 SHALL on an accepted error request: write no memory, go IDLE->RESP; next cycle resp_valid=1, resp_err=1, resp_rdata=0.
REQ-019 SHALL on an accepted legal store: write the addressed bytes at the acceptance edge (SB one lane, SH lanes {1,0} or {3,2}, SW all four; little-endian); go IDLE->RESP; resp_valid=1, resp_err=0, resp_rdata=0 the next cycle.
REQ-020 SHALL on an accepted legal load: latch addr/type, load a down-counter with READ_LATENCY-1, go IDLE->LOAD_WAIT, or IDLE->RESP directly when READ_LATENCY=1.
REQ-021 SHALL in LOAD_WAIT decrement the counter each cycle and enter RESP when it reaches 0; total delay from acceptance edge to resp_valid high is exactly READ_LATENCY cycles.
REQ-022 SHALL in RESP drive resp_valid=1 for exactly one cycle, then return to IDLE; req_ready is 0 during RESP, so the earliest next acceptance is the edge ending the RESP cycle.
REQ-023 SHALL form load data from the aligned word containing the address: LB/LH sign-extend, LBU/LHU zero-extend, LW unmodified; byte lane selected by addr[1:0], halfword by addr[1].
REQ-024 SHALL return memory contents as of the load response edge; a store can never overlap a pending load (single outstanding request).
REQ-025 SHALL hold resp_rdata and resp_err at 0 whenever resp_valid=0.
REQ-026 SHALL treat addresses modulo 2**ADDR_WIDTH; no out-of-range error exists.

Reset
REQ-027 SHALL on rst=0, immediately and asynchronously: FSM=IDLE, counter=0, resp_valid=0, resp_rdata=0, resp_err=0; req_ready=0 while rst=0 and 1 from the first cycle after release.
REQ-028 SHALL discard any in-flight load or pending response on reset; no response is issued for it.
REQ-029 SHALL NOT initialise or clear memory contents on reset; contents are undefined until written.

Verification
REQ-030 SHALL cover: SW 0xDEADBEEF @0x010, then LW @0x010 -> store ack (resp_err=0, resp_rdata=0), then load response 0xDEADBEEF exactly READ_LATENCY cycles after acceptance.
REQ-031 SHALL cover: SB 0x80 @0x013 over word 0x00000000, then LB @0x013 -> 0xFFFFFF80; LBU @0x013 -> 0x00000080; LH @0x012 -> 0xFFFF8000; LHU @0x012 -> 0x00008000.
REQ-032 SHALL cover: SW @0x002, SH @0x001, LW @0x003, store_type 11, load_type 101 -> each resp_err=1, resp_rdata=0, one cycle after acceptance; memory at 0x000-0x003 unchanged.
REQ-033 SHALL cover: READ_LATENCY=3 build, req_valid held high continuously -> req_ready low for 3 cycles after each load acceptance, one resp_valid pulse per request, no request lost or duplicated.
REQ-034 SHALL cover: assert rst=0 mid-LOAD_WAIT (READ_LATENCY=4) -> resp_valid stays 0, no stale response after release, previously written data still readable.
